// File: rtl/postage_deadlock_reporter.sv
// Postage deadlock reporter: debounces the monitor block flag, decodes stalled AXIS channels
// and issues one report per episode. Define POSTAGE_DEADLOCK_TIMESTAMP_EN to timestamp reports.
module postage_deadlock_reporter #(
    parameter int NUM_CHAN = 10,
    parameter int THRESH   = 16,
    parameter int CNT_W    = 32,
    parameter int IDX_W    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         block,
    input  logic [NUM_CHAN*NUM_CHAN-1:0] axis_block_info,
    input  logic                         clear,
    output logic                         rpt_valid,
    input  logic                         rpt_ready,
    output logic [NUM_CHAN-1:0]          rpt_mask,
    output logic [IDX_W-1:0]             rpt_first,
    output logic [CNT_W-1:0]             rpt_cycle,
    output logic                         rpt_malformed,
    output logic                         deadlock
);

    localparam int PW = $clog2(THRESH + 1);
    localparam logic [PW-1:0] LAST = PW'(THRESH - 1);

    typedef enum logic [1:0] {IDLE, WATCH, REPORT, HOLD} state_t;

    state_t               state, state_n;
    logic [PW-1:0]        cnt, cnt_n;
    logic                 mal_acc, mal_n;
    logic                 capture;
    logic [NUM_CHAN-1:0]  active;
    logic [NUM_CHAN-1:0]  bad;
    logic [NUM_CHAN-1:0]  field;
    logic                 malformed;
    logic [IDX_W-1:0]     first_idx;

    // A healthy field is all ones except its own channel bit, or all zeros.
    always_comb begin
        active = '0;
        bad    = '0;
        field  = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            field     = axis_block_info[i*NUM_CHAN +: NUM_CHAN];
            active[i] = (field == ~(NUM_CHAN'(1) << i));
            bad[i]    = (field != '0) && !active[i];
        end
        malformed = (|bad) | (block && (active == '0));
    end

    always_comb begin
        first_idx = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (active[i]) first_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mal_n   = mal_acc;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (block) begin
                    if (THRESH == 1) begin
                        capture = 1'b1;
                        state_n = REPORT;
                    end else begin
                        state_n = WATCH;
                        cnt_n   = PW'(1);
                        mal_n   = malformed;
                    end
                end
            end
            WATCH: begin
                if (!block) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    mal_n   = 1'b0;
                end else if (cnt == LAST) begin
                    capture = 1'b1;
                    state_n = REPORT;
                    cnt_n   = '0;
                    mal_n   = 1'b0;
                end else begin
                    cnt_n = cnt + PW'(1);
                    mal_n = mal_acc | malformed;
                end
            end
            REPORT: begin
                if (rpt_ready) state_n = HOLD;
            end
            HOLD: begin
                if (!block) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rpt_valid = (state == REPORT);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            mal_acc       <= 1'b0;
            rpt_mask      <= '0;
            rpt_first     <= '0;
            rpt_malformed <= 1'b0;
            deadlock      <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mal_acc <= mal_n;
            if (capture) begin
                rpt_mask      <= active;
                rpt_first     <= first_idx;
                rpt_malformed <= mal_acc | malformed;
            end
            // A capture in the same cycle as clear keeps the flag set.
            if (capture) deadlock <= 1'b1;
            else if (clear) deadlock <= 1'b0;
        end
    end

`ifdef POSTAGE_DEADLOCK_TIMESTAMP_EN
    logic [CNT_W-1:0] stamp;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stamp     <= '0;
            rpt_cycle <= '0;
        end else begin
            stamp <= stamp + CNT_W'(1);
            if (capture) rpt_cycle <= stamp;
        end
    end
`else
    assign rpt_cycle = '0;
`endif

endmodule

// File: doc/postage_deadlock_reporter.md
Name: postage_deadlock_reporter

Overview:
- Consumer side of the postage deadlock monitor.
- Takes the monitor's `block` flag and its per-channel inverted one-hot `axis_block_info` fields.
- Requires blocking to persist for THRESH consecutive cycles, then decodes which AXIS channels are stalled.
- Issues one timestamped report over a valid/ready interface per deadlock episode; a sticky `deadlock` flag goes to the debug/status path.

Parameters:
- NUM_CHAN, 10: number of monitored AXIS channels. Info bus is NUM_CHAN*NUM_CHAN bits, field i = bits [i*NUM_CHAN +: NUM_CHAN].
- THRESH, 16: consecutive blocked cycles required before a report (>=1).
- CNT_W, 32: timestamp counter width.
- IDX_W, $clog2(NUM_CHAN) (min 1): channel index width.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- block  in  1  monitor block flag
- axis_block_info  in  NUM_CHAN*NUM_CHAN  per-channel info fields
- clear  in  1  pulse; clears sticky deadlock flag
- rpt_valid  out  1  report available
- rpt_ready  in  1  report accepted when high with rpt_valid
- rpt_mask  out  NUM_CHAN  bit i set = channel i blocked at capture
- rpt_first  out  IDX_W  lowest set index of rpt_mask (0 if mask empty)
- rpt_cycle  out  CNT_W  timestamp at capture
- rpt_malformed  out  1  malformed info observed during the episode
- deadlock  out  1  sticky; set on report capture

Behaviour:
- Reset (reset_n=0 at a rising edge): state IDLE, persist count 0, timestamp 0, all outputs 0. Applies mid-operation, including during REPORT. A pending report is discarded.
- Field decode, combinational, per field i:
  - active_i = (field == ~(1<<i)), NUM_CHAN bits wide.
  - bad_i = (field != 0) && !active_i.
  - Cycle malformed = OR(bad_i) | (block && active==0).
- Timestamp: free-running, +1 every cycle, wraps 2^CNT_W-1 -> 0.
- FSM states: IDLE, WATCH, REPORT, HOLD.
  - IDLE:
    - block=1 and THRESH=1 -> REPORT, capture this cycle.
    - block=1 otherwise -> WATCH with cnt=1, mal_acc = cycle malformed.
  - WATCH:
    - block=0 -> IDLE, cnt=0, mal_acc=0.
    - block=1 and cnt==THRESH-1 -> REPORT with capture.
    - block=1 otherwise -> cnt+1, mal_acc |= cycle malformed.
  - Capture, registered on the transition edge:
    - rpt_mask = current active.
    - rpt_first = lowest set index.
    - rpt_cycle = timestamp.
    - rpt_malformed = mal_acc | cycle malformed.
    - deadlock <= 1.
  - REPORT:
    - rpt_valid=1.
    - All rpt_* fields held stable while rpt_ready=0.
    - rpt_valid & rpt_ready -> HOLD; rpt_valid drops the next cycle.
    - block changes are ignored.
  - HOLD:
    - No new report while block=1.
    - block=0 -> IDLE (re-arm).
- Latency: with block first seen high at cycle 0 and held, rpt_valid rises at cycle THRESH.
- rpt_* hold their last captured values outside REPORT.
- clear: deadlock <= 0 unless a capture occurs the same cycle (set wins). Does not affect FSM or rpt_valid.
- cnt saturates logically at THRESH-1; width $clog2(THRESH+1).

Optional Feature:
- Macro: POSTAGE_DEADLOCK_TIMESTAMP_EN.
- Defined: timestamp counter is instantiated and rpt_cycle is driven as above.
- Undefined: no counter is instantiated and rpt_cycle is tied to 0. All other behaviour is identical.

Test Plan:
- THRESH=16; field 3 = 10'h3F7, block=1 for 15 cycles, then 0 -> rpt_valid never rises, deadlock=0.
- Field 3 = 10'h3F7, block=1 held from cycle 0 -> rpt_valid=1 at cycle 16, rpt_mask=10'h008, rpt_first=3, rpt_malformed=0, deadlock=1; with macro defined, rpt_cycle = timestamp at cycle 15 edge.
- Fields 2 = 10'h3FB and 7 = 10'h37F, block held 16 cycles -> rpt_mask=10'h084, rpt_first=2.
- Field 5 = 10'h3FF for one cycle mid-window, block held -> rpt_malformed=1. Separately, block=1 with all fields 0 -> rpt_malformed=1, rpt_mask=0, rpt_first=0.
- Hold rpt_ready=0 for 5 cycles in REPORT -> rpt_valid and all rpt_* stable. Then ready=1 -> rpt_valid=0 next cycle. block stays high 20 more cycles -> no new report. block low 1 cycle, then high 16 cycles -> second report.
- Pulse clear while deadlock=1 -> deadlock=0 next cycle. Assert reset_n=0 for one cycle during REPORT -> rpt_valid=0, deadlock=0, state IDLE.
